beat_timer: RTL and testbench

- Beat (W-phase) generator upstream of the hardwired controller.
- Produces the one-hot machine-cycle beats W[3:1] that the controller decodes.
- Consumes the controller's SHORT, LONG and STOP outputs to decide each cycle's length and whether to halt after it.
- Owns the run/halt state: started by the console QD button, with an optional single-step mode.

---
 rtl/cpu_timing_pkg.sv | 17 +
 rtl/qd_sync.sv | 28 ++
 rtl/beat_timer.sv | 120 ++++++++++++
 tb/tb_beat_timer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_timing_pkg.sv
// Shared timing definitions for the beat generator and the hardwired controller:
// run/halt state, one-hot beat encodings and the default cycle-counter width.
package cpu_timing_pkg;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] W_NONE = 3'b000;
    localparam logic [2:0] W_1    = 3'b001;
    localparam logic [2:0] W_2    = 3'b010;
    localparam logic [2:0] W_3    = 3'b100;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/qd_sync.sv
// Console QD button synchroniser into the T3 domain with a rising-edge detector;
// emits a one-T3 start pulse per new press.
module qd_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic T3,
    input  logic CLR,
    input  logic QD,
    output logic start
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus one delayed copy of its output for edge detection
    always_ff @(posedge T3) begin
        if (!CLR) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], QD};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign start = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/beat_timer.sv
// Machine-cycle beat generator W[3:1] with run/halt control and cycle counter.
// Optional macro CYCLE_LIMIT_EN: halt when the completed-cycle count reaches CYC_LIMIT.
module beat_timer
    import cpu_timing_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             T3,
    input  logic             CLR,
    input  logic             QD,
    input  logic             STEP,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    input  logic [CNT_W-1:0] CYC_LIMIT,
    output logic [2:0]       W,
    output logic             RUN,
    output logic             CYC_END,
    output logic [CNT_W-1:0] CYC_CNT
);

    state_t           state_r;
    logic             start_s;
    logic             cyc_end_s;
    logic             limit_hit_s;
    logic             halt_req_s;
    logic [CNT_W-1:0] cnt_inc_s;

    qd_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_qd_sync (
        .T3   (T3),
        .CLR  (CLR),
        .QD   (QD),
        .start(start_s)
    );

    assign cnt_inc_s = CYC_CNT + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef CYCLE_LIMIT_EN
    assign limit_hit_s = (CYC_LIMIT != {CNT_W{1'b0}}) && (cnt_inc_s == CYC_LIMIT);
`else
    logic unused_cyc_limit_s;
    assign unused_cyc_limit_s = ^CYC_LIMIT;
    assign limit_hit_s        = 1'b0;
`endif

    assign halt_req_s = STOP | STEP | limit_hit_s;

    // The controller's SHORT/LONG answer within the current beat decides whether it is the last
    always_comb begin
        cyc_end_s = 1'b0;
        if (state_r == ST_RUN) begin
            case (W)
                W_1:     cyc_end_s = SHORT;
                W_2:     cyc_end_s = ~LONG;
                W_3:     cyc_end_s = 1'b1;
                default: cyc_end_s = 1'b0;
            endcase
        end else begin
            cyc_end_s = 1'b0;
        end
    end

    assign CYC_END = cyc_end_s;

    // Run/halt state machine, beat register and completed-cycle counter
    always_ff @(posedge T3) begin
        if (!CLR) begin
            state_r <= ST_HALT;
            W       <= W_NONE;
            RUN     <= 1'b0;
            CYC_CNT <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_HALT: begin
                    if (start_s) begin
                        state_r <= ST_RUN;
                        W       <= W_1;
                        RUN     <= 1'b1;
                    end else begin
                        W       <= W_NONE;
                        RUN     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cyc_end_s) begin
                        CYC_CNT <= cnt_inc_s;
                        if (halt_req_s) begin
                            state_r <= ST_HALT;
                            W       <= W_NONE;
                            RUN     <= 1'b0;
                        end else begin
                            W       <= W_1;
                            RUN     <= 1'b1;
                        end
                    end else begin
                        case (W)
                            W_1:     W <= W_2;
                            W_2:     W <= W_3;
                            default: begin
                                // Corrupt beat encoding: drop to a safe halt
                                state_r <= ST_HALT;
                                W       <= W_NONE;
                                RUN     <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_r <= ST_HALT;
                    W       <= W_NONE;
                    RUN     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beat_timer.sv
// Self-checking bench for beat_timer (CNT_W=4): table-driven beats checked through a scoreboard queue.
module tb_beat_timer;

    typedef struct {
        logic       clr;
        logic       qd;
        logic       step;
        logic       sh;
        logic       lg;
        logic       sp;
        logic [2:0] ew;
        logic       erun;
        logic       eend;
        logic [3:0] ecnt;
    } vec_t;

    logic       T3;
    logic       CLR;
    logic       QD;
    logic       STEP;
    logic       SHORT;
    logic       LONG;
    logic       STOP;
    logic [3:0] CYC_LIMIT;
    logic [2:0] W;
    logic       RUN;
    logic       CYC_END;
    logic [3:0] CYC_CNT;

    int   n_checks;
    int   n_fail;
    int   beat_no;
    vec_t sb_q[$];
    vec_t tbl[32];

    beat_timer #(.CNT_W(4), .SYNC_STAGES(2)) dut (
        .T3       (T3),
        .CLR      (CLR),
        .QD       (QD),
        .STEP     (STEP),
        .SHORT    (SHORT),
        .LONG     (LONG),
        .STOP     (STOP),
        .CYC_LIMIT(CYC_LIMIT),
        .W        (W),
        .RUN      (RUN),
        .CYC_END  (CYC_END),
        .CYC_CNT  (CYC_CNT)
    );

    initial T3 = 1'b0;
    always #5 T3 = ~T3;

    function automatic vec_t mk(input logic clr, input logic qd, input logic step,
                                input logic sh, input logic lg, input logic sp,
                                input logic [2:0] ew, input logic erun,
                                input logic eend, input logic [3:0] ecnt);
        vec_t v;
        v.clr = clr; v.qd = qd; v.step = step; v.sh = sh; v.lg = lg; v.sp = sp;
        v.ew = ew; v.erun = erun; v.eend = eend; v.ecnt = ecnt;
        return v;
    endfunction

    // Drive one beat's inputs, queue its expectation, compare mid-beat, advance past the edge
    task automatic beat(input string name, input vec_t v);
        vec_t e;
        CLR = v.clr; QD = v.qd; STEP = v.step; SHORT = v.sh; LONG = v.lg; STOP = v.sp;
        sb_q.push_back(v);
        @(negedge T3);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s beat %0d: scoreboard empty", name, beat_no);
        end else begin
            e = sb_q.pop_front();
            if (W !== e.ew || RUN !== e.erun || CYC_END !== e.eend || CYC_CNT !== e.ecnt) begin
                n_fail++;
                $display("FAIL %s beat %0d: got W=%b RUN=%b CYC_END=%b CYC_CNT=%0d, required W=%b RUN=%b CYC_END=%b CYC_CNT=%0d",
                         name, beat_no, W, RUN, CYC_END, CYC_CNT, e.ew, e.erun, e.eend, e.ecnt);
            end
        end
        n_checks++;
        if (!((RUN === 1'b1 && $onehot(W)) || (RUN === 1'b0 && W === 3'b000))) begin
            n_fail++;
            $display("FAIL onehot beat %0d: got W=%b RUN=%b, required one-hot W while RUN, W=000 otherwise",
                     beat_no, W, RUN);
        end
        beat_no++;
        @(posedge T3);
        #1;
    endtask

    // Press QD from halt: three beats until W1 appears
    task automatic press(input string name, input logic step, input logic [3:0] cnt);
        for (int k = 0; k < 3; k++) beat(name, mk(1'b1, 1'b1, step, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, cnt));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; beat_no = 0;
        CLR = 1'b0; QD = 1'b0; STEP = 1'b0; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
        CYC_LIMIT = 4'd0;

        //            clr   qd    step  sh    lg    sp    W       RUN   END   CNT
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'd0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 4'd0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'd1);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 4'd1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 4'd2);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 4'd2);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 4'd2);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 4'd3);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 4'd4);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 4'd5);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'd6);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 4'd6);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 4'd6);
        tbl[18] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 4'd7);
        tbl[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 4'd7);
        tbl[20] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 4'd7);
        tbl[21] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[22] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[23] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[24] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[25] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[26] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[27] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[28] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd8);
        tbl[29] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'd8);
        tbl[30] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 4'd8);
        tbl[31] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);

        repeat (2) @(posedge T3);
        #1;

        for (int i = 0; i < 32; i++) beat("table", tbl[i]);

        // Single-step: one machine cycle per press
        for (int p = 0; p < 3; p++) begin
            press("step_press", 1'b1, 4'(p));
            beat("step_w1", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'(p)));
            beat("step_w2", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 4'(p)));
            for (int k = 0; k < 3; k++)
                beat("step_halt", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'(p + 1)));
        end

        // Counter wrap: 17 single-beat cycles on a 4-bit counter
        beat("wrap_rst", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd3));
        beat("wrap_idle", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        press("wrap_press", 1'b0, 4'd0);
        for (int i = 0; i < 17; i++)
            beat("wrap_run", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 4'(i)));
        beat("wrap_val", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 4'd1));
        beat("wrap_stop", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd2));

        // Cycle limit of 5
        CYC_LIMIT = 4'd5;
        beat("lim_rst", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd2));
        beat("lim_idle", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
        press("lim_press", 1'b0, 4'd0);
        for (int i = 0; i < 5; i++)
            beat("lim_run", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 4'(i)));
`ifdef CYCLE_LIMIT_EN
        beat("lim_halt", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd5));
        beat("lim_stay", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd5));
`else
        beat("lim_past", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 4'd5));
        beat("lim_stop", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd6));
`endif
        CYC_LIMIT = 4'd0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
